// File: rtl/parity_pkg.sv
// Shared types and constants for the two-requester parity arbiter.
package parity_pkg;

  localparam int unsigned NREQ = 2;

  typedef logic req_id_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    EVAL    = 3'd2,
    DONE    = 3'd3,
    RELEASE = 3'd4
  } state_t;

endpackage

// File: rtl/even_parity4.sv
// Combinational 4-bit even-parity generator and checker.
module even_parity4 (
  input  logic [3:0] data,
  input  logic       pin,
  output logic       p_c,
  output logic       e_c
);

  // Parity is the XOR of the nibble; error flags a received bit that disagrees.
  assign p_c = ^data;
  assign e_c = pin ^ p_c;

endmodule

// File: rtl/parity_arbiter_ctrl.sv
// Round-robin controller sharing one even_parity4 between two requesters.
module parity_arbiter_ctrl
  import parity_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [3:0]       data0,
  input  logic             pin0,
  input  logic             req1,
  input  logic [3:0]       data1,
  input  logic             pin1,
  input  logic             clr,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic             p,
  output logic             e,
  output logic [CNT_W-1:0] err_cnt0,
  output logic [CNT_W-1:0] err_cnt1
);

  state_t            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  req_id_t           done_id_q, done_id_d;
  logic              p_q, p_d;
  logic              e_q, e_d;
  req_id_t           id_q, id_d;
  req_id_t           last_id_q, last_id_d;
  logic [3:0]        opnd_q, opnd_d;
  logic              pin_q, pin_d;
  logic [CNT_W-1:0]  cnt0_q, cnt0_d;
  logic [CNT_W-1:0]  cnt1_q, cnt1_d;

  logic [NREQ-1:0]   req_vec;
  req_id_t           win_id;
  logic              par_p, par_e;

  assign req_vec = {req1, req0};

  // Single shared parity unit, fed only from the captured operand.
  even_parity4 u_parity (
    .data (opnd_q),
    .pin  (pin_q),
    .p_c  (par_p),
    .e_c  (par_e)
  );

  // Round-robin pick: on a tie the requester not served last wins.
  always_comb begin
    win_id = req_id_t'(req1);
    if (req0 && req1) begin
      win_id = ~last_id_q;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; RELEASE waits for the granted request to drop.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|req_vec) state_d = LOAD;
      LOAD:    state_d = EVAL;
      EVAL:    state_d = DONE;
      DONE:    state_d = RELEASE;
      RELEASE: if (!req_vec[id_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values, all registered below.
  always_comb begin
    gnt_d     = gnt_q;
    busy_d    = (state_d != IDLE);
    done_d    = 1'b0;
    done_id_d = done_id_q;
    p_d       = p_q;
    e_d       = e_q;
    id_d      = id_q;
    last_id_d = last_id_q;
    opnd_d    = opnd_q;
    pin_d     = pin_q;
    cnt0_d    = cnt0_q;
    cnt1_d    = cnt1_q;

    case (state_q)
      IDLE: begin
        if (|req_vec) begin
          id_d   = win_id;
          gnt_d  = NREQ'(1) << win_id;
          opnd_d = win_id ? data1 : data0;
          pin_d  = win_id ? pin1 : pin0;
        end
      end
      LOAD: begin
        p_d = par_p;
        e_d = par_e;
      end
      EVAL: begin
        done_d    = 1'b1;
        done_id_d = id_q;
        last_id_d = id_q;
      end
      DONE: begin
        if (e_q) begin
          if (id_q == 1'b0) begin
            if (!(&cnt0_q)) cnt0_d = cnt0_q + CNT_W'(1);
          end else begin
            if (!(&cnt1_q)) cnt1_d = cnt1_q + CNT_W'(1);
          end
        end
      end
      RELEASE: begin
        if (!req_vec[id_q]) gnt_d = '0;
      end
      default: begin
        gnt_d = '0;
      end
    endcase

    // Clear takes priority over a same-cycle increment.
    if (clr) begin
      cnt0_d = '0;
      cnt1_d = '0;
    end
  end

  // Registered outputs and operand/arbitration state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      p_q       <= 1'b0;
      e_q       <= 1'b0;
      id_q      <= 1'b0;
      last_id_q <= 1'b1;
      opnd_q    <= '0;
      pin_q     <= 1'b0;
      cnt0_q    <= '0;
      cnt1_q    <= '0;
    end else begin
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      p_q       <= p_d;
      e_q       <= e_d;
      id_q      <= id_d;
      last_id_q <= last_id_d;
      opnd_q    <= opnd_d;
      pin_q     <= pin_d;
      cnt0_q    <= cnt0_d;
      cnt1_q    <= cnt1_d;
    end
  end

  assign gnt      = gnt_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign done_id  = done_id_q;
  assign p        = p_q;
  assign e        = e_q;
  assign err_cnt0 = cnt0_q;
  assign err_cnt1 = cnt1_q;

endmodule

// File: tb/tb_parity_arbiter_ctrl.sv
// Directed plus randomized bench for parity_arbiter_ctrl against a transaction-level model.
module tb_parity_arbiter_ctrl;

  localparam int unsigned CNT_W = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  logic req0, req1, pin0, pin1, clr;
  logic [3:0] data0, data1;
  logic [1:0] gnt;
  logic busy, done, done_id, p, e;
  logic [CNT_W-1:0] err_cnt0, err_cnt1;

  int vectors = 0;
  int miscompares = 0;

  // Transaction-level model state
  int m_last_id;
  int m_cnt [2];

  parity_arbiter_ctrl #(.CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req0     (req0),
    .data0    (data0),
    .pin0     (pin0),
    .req1     (req1),
    .data1    (data1),
    .pin1     (pin1),
    .clr      (clr),
    .gnt      (gnt),
    .busy     (busy),
    .done     (done),
    .done_id  (done_id),
    .p        (p),
    .e        (e),
    .err_cnt0 (err_cnt0),
    .err_cnt1 (err_cnt1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_last_id = 1;
    m_cnt[0] = 0;
    m_cnt[1] = 0;
  endtask

  task automatic chk_cnts(input string tag);
    chk({tag, "_cnt0"}, 16'(err_cnt0), 16'(m_cnt[0]));
    chk({tag, "_cnt1"}, 16'(err_cnt1), 16'(m_cnt[1]));
  endtask

  // One full request/done/release transaction; the loser (if any) keeps requesting.
  task automatic txn(input logic r0, input logic r1, input logic [3:0] d0, input logic [3:0] d1,
                     input logic pn0, input logic pn1, input bit glitch, input bit clr_done,
                     input int hold);
    int w;
    int ep, ee;
    logic [3:0] dw;
    logic pw;
    req0 = r0; req1 = r1; data0 = d0; data1 = d1; pin0 = pn0; pin1 = pn1;
    if (r0 && r1) w = 1 - m_last_id;
    else w = r1 ? 1 : 0;
    dw = (w == 1) ? d1 : d0;
    pw = (w == 1) ? pn1 : pn0;
    ep = 0;
    for (int i = 0; i < 4; i++) if (dw[i]) ep = 1 - ep;
    ee = (ep != int'(pw)) ? 1 : 0;

    step();
    chk("grant", 16'(gnt), 16'(1 << w));
    chk("busy_grant", 16'(busy), 16'(1));
    chk("done_early", 16'(done), 16'(0));
    if (glitch) begin
      data0 = 4'b0000; data1 = 4'b0000; pin0 = ~pn0; pin1 = ~pn1;
    end

    step();
    chk("done_eval", 16'(done), 16'(0));

    step();
    chk("done_pulse", 16'(done), 16'(1));
    chk("done_id", 16'(done_id), 16'(w));
    chk("p", 16'(p), 16'(ep));
    chk("e", 16'(e), 16'(ee));
    chk("gnt_done", 16'(gnt), 16'(1 << w));
    clr = clr_done;

    step();
    clr = 1'b0;
    if (clr_done) begin
      m_cnt[0] = 0;
      m_cnt[1] = 0;
    end else if (ee == 1 && m_cnt[w] < CNT_MAX) begin
      m_cnt[w]++;
    end
    chk("done_once", 16'(done), 16'(0));
    chk_cnts("after_done");
    chk("gnt_release", 16'(gnt), 16'(1 << w));

    for (int h = 0; h < hold; h++) begin
      step();
      chk("gnt_hold", 16'(gnt), 16'(1 << w));
      chk("done_hold", 16'(done), 16'(0));
    end

    if (w == 0) req0 = 1'b0;
    else req1 = 1'b0;
    step();
    chk("gnt_drop", 16'(gnt), 16'(0));
    chk("busy_idle", 16'(busy), 16'(0));
    m_last_id = w;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_gnt", 16'(gnt), 16'(0));
    chk("rst_busy", 16'(busy), 16'(0));
    chk("rst_done", 16'(done), 16'(0));
    chk("rst_done_id", 16'(done_id), 16'(0));
    chk("rst_p", 16'(p), 16'(0));
    chk("rst_e", 16'(e), 16'(0));
    model_reset();
    chk_cnts("rst");
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    int r, loser;
    rst_n = 1'b1;
    req0 = 1'b0; req1 = 1'b0; pin0 = 1'b0; pin1 = 1'b0; clr = 1'b0;
    data0 = 4'h0; data1 = 4'h0;
    model_reset();
    #2;
    do_reset();

    // Single requesters, clean and erroneous
    txn(1'b1, 1'b0, 4'b0101, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    txn(1'b0, 1'b1, 4'h0, 4'b1011, 1'b0, 1'b0, 1'b0, 1'b0, 2);

    // Simultaneous requests after reset: 0 then 1, twice
    do_reset();
    txn(1'b1, 1'b1, 4'b0011, 4'b0111, 1'b1, 1'b1, 1'b0, 1'b0, 1);
    txn(1'b0, 1'b1, 4'h0, 4'b0111, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    txn(1'b1, 1'b1, 4'b1110, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    txn(1'b0, 1'b1, 4'h0, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, 0);

    // Saturation and clear
    do_reset();
    for (int k = 0; k < 5; k++) begin
      txn(1'b1, 1'b0, 4'b0001, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    end
    clr = 1'b1;
    step();
    clr = 1'b0;
    m_cnt[0] = 0;
    m_cnt[1] = 0;
    chk_cnts("clr_pulse");
    txn(1'b1, 1'b0, 4'b0001, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    txn(1'b1, 1'b0, 4'b0001, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 0);

    // Operand changes after grant are ignored
    txn(1'b1, 1'b0, 4'b0111, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 0);

    // Reset during EVAL aborts with counters and result cleared
    txn(1'b0, 1'b1, 4'h0, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    req0 = 1'b1; data0 = 4'b0001; pin0 = 1'b0;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("abort_gnt", 16'(gnt), 16'(0));
    chk("abort_busy", 16'(busy), 16'(0));
    chk("abort_done", 16'(done), 16'(0));
    chk("abort_p", 16'(p), 16'(0));
    chk("abort_e", 16'(e), 16'(0));
    chk_cnts("abort");
    step();
    chk("abort_no_done", 16'(done), 16'(0));
    req0 = 1'b0;
    rst_n = 1'b1;
    step();
    chk("abort_idle", 16'(busy), 16'(0));

    // Randomized traffic
    for (int n = 0; n < 30; n++) begin
      r = $urandom_range(1, 3);
      txn(r[0], r[1], 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
          1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), $urandom_range(0, 2));
      if (r == 3) begin
        loser = 1 - m_last_id;
        txn(loser == 0, loser == 1, 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom_range(0, 1)), 1'b0, $urandom_range(0, 2));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
